data_mem_lsu: RTL and testbench



---
 rtl/data_mem_lsu.sv | 133 +++++++++++++
 tb/tb_data_mem_lsu.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lsu.sv
// Memory-stage LSU: word RAM with byte/half merge, load extension, and MMIO (cycle counter, GPIO, store fault).
// Latency: loads combinational, stores commit on the clk edge; backpressure: none, one access accepted every cycle.
module data_mem_lsu #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic [7:0]  gpio_out,
  output logic        fault
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [63:0]   cycleCnt;
  logic [7:0]    gpioReg;
  logic          faultReg;
  logic [31:0]   faultAddr;

  logic          isMmio;
  logic [AW-1:0] wordIdx;
  logic [31:0]   mmioWord;
  logic [31:0]   rawWord;
  logic [7:0]    loadByte;
  logic [15:0]   loadHalf;
  logic          misaligned;
  logic          storeOk;
  logic          storeFault;
  logic          mmioWordStore;
  logic [3:0]    byteEn;
  logic [31:0]   storeData;

  assign isMmio  = (addr[31:6] == MMIO_BASE[31:6]);
  assign wordIdx = addr[AW+1:2];

  always_comb begin
    mmioWord = '0;
    case (addr[5:2])
      4'd0:    mmioWord = cycleCnt[31:0];
      4'd1:    mmioWord = cycleCnt[63:32];
      4'd2:    mmioWord = {24'd0, gpioReg};
      4'd3:    mmioWord = {31'd0, faultReg};
      4'd4:    mmioWord = faultAddr;
      default: mmioWord = '0;
    endcase
  end

  assign rawWord = isMmio ? mmioWord : mem[wordIdx];

  always_comb begin
    loadByte = rawWord[7:0];
    case (addr[1:0])
      2'd0: loadByte = rawWord[7:0];
      2'd1: loadByte = rawWord[15:8];
      2'd2: loadByte = rawWord[23:16];
      2'd3: loadByte = rawWord[31:24];
    endcase
    loadHalf = addr[1] ? rawWord[31:16] : rawWord[15:0];
    rd = '0;
    case (funct3)
      3'b000:  rd = {{24{loadByte[7]}}, loadByte};
      3'b001:  rd = {{16{loadHalf[15]}}, loadHalf};
      3'b010:  rd = rawWord;
      3'b100:  rd = {24'd0, loadByte};
      3'b101:  rd = {16'd0, loadHalf};
      default: rd = '0;
    endcase
  end

  // Store decode: replicate the data across lanes and let byteEn pick the target lanes.
  always_comb begin
    misaligned = 1'b0;
    byteEn     = 4'b0000;
    storeData  = wd;
    case (funct3)
      3'b000: begin
        byteEn    = 4'b0001 << addr[1:0];
        storeData = {4{wd[7:0]}};
      end
      3'b001: begin
        misaligned = addr[0];
        byteEn     = addr[1] ? 4'b1100 : 4'b0011;
        storeData  = {2{wd[15:0]}};
      end
      3'b010: begin
        misaligned = |addr[1:0];
        byteEn     = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign storeFault    = we & misaligned;
  assign storeOk       = we & ~misaligned;
  assign mmioWordStore = storeOk & isMmio & (funct3 == 3'b010);

  // RAM is not reset, but a store coinciding with reset is still dropped.
  always_ff @(posedge clk) begin
    if (storeOk && !isMmio && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycleCnt  <= '0;
      gpioReg   <= '0;
      faultReg  <= 1'b0;
      faultAddr <= '0;
    end else begin
      cycleCnt <= cycleCnt + 64'd1;
      if (mmioWordStore && addr[5:2] == 4'd2) gpioReg <= wd[7:0];
      if (storeFault) begin
        faultReg <= 1'b1;
        if (!faultReg) faultAddr <= addr;
      end else if (mmioWordStore && addr[5:2] == 4'd3 && wd[0]) begin
        faultReg <= 1'b0;
      end
    end
  end

  assign gpio_out = gpioReg;
  assign fault    = faultReg;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: vector table, hand-written multi-cycle sequences, randomized RAM traffic vs byte-array model.
module tb_data_mem_lsu;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] MB    = 32'hFFFF0000;

  logic        clk;
  logic        reset;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic [7:0]  gpio_out;
  logic        fault;

  data_mem_lsu #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB)) dut (
    .clk(clk), .reset(reset), .we(we), .funct3(funct3), .addr(addr),
    .wd(wd), .rd(rd), .gpio_out(gpio_out), .fault(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Store: inputs applied at negedge, committed at posedge, we dropped just after.
  task automatic doStore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; funct3 = f3; addr = a; wd = d;
    @(posedge clk);
    #1 we = 1'b0;
  endtask

  task automatic doLoad(input logic [2:0] f3, input logic [31:0] a, output logic [31:0] r);
    @(negedge clk);
    we = 1'b0; funct3 = f3; addr = a;
    #1 r = rd;
  endtask

  // Byte-addressed reference RAM (index = address modulo RAM size).
  logic [7:0]  mMem [4*DEPTH];
  logic        mFault;
  logic [31:0] mFaultAddr;

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] a);
    logic [11:0] ra, wb, hb;
    int v;
    ra = a[11:0];
    wb = {ra[11:2], 2'b00};
    hb = {ra[11:1], 1'b0};
    case (f3)
      3'd0: begin v = int'(mMem[ra]); if (v > 127) v -= 256; return 32'(v); end
      3'd1: begin v = int'(mMem[hb]) + 256 * int'(mMem[hb + 12'd1]); if (v > 32767) v -= 65536; return 32'(v); end
      3'd2: return {mMem[wb + 12'd3], mMem[wb + 12'd2], mMem[wb + 12'd1], mMem[wb]};
      3'd4: return 32'(mMem[ra]);
      3'd5: return 32'(int'(mMem[hb]) + 256 * int'(mMem[hb + 12'd1]));
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic storeLegal(input logic [2:0] f3, input logic [31:0] a);
    return (f3 == 3'd0) || (f3 == 3'd1 && a[0] == 1'b0) || (f3 == 3'd2 && a[1:0] == 2'b00);
  endfunction

  task automatic modelStore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    logic [11:0] ra, wb, hb;
    ra = a[11:0];
    wb = {ra[11:2], 2'b00};
    hb = {ra[11:1], 1'b0};
    if (!storeLegal(f3, a)) begin
      if (!mFault) mFaultAddr = a;
      mFault = 1'b1;
    end else if (f3 == 3'd0) begin
      mMem[ra] = d[7:0];
    end else if (f3 == 3'd1) begin
      mMem[hb] = d[7:0];
      mMem[hb + 12'd1] = d[15:8];
    end else begin
      for (int k = 0; k < 4; k++) mMem[wb + 12'(k)] = d[8*k +: 8];
    end
  endtask

  typedef struct packed {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [20];
  logic [31:0] r, r2;

  initial begin
    reset = 1'b1; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wd = 32'd0;
    mFault = 1'b0; mFaultAddr = 32'd0;

    vecs[0]  = '{1'b1, 3'b010, 32'h10,   32'h800000FF, 32'h0};
    vecs[1]  = '{1'b0, 3'b000, 32'h10,   32'h0,        32'hFFFFFFFF};
    vecs[2]  = '{1'b0, 3'b100, 32'h10,   32'h0,        32'h000000FF};
    vecs[3]  = '{1'b0, 3'b001, 32'h10,   32'h0,        32'h000000FF};
    vecs[4]  = '{1'b0, 3'b101, 32'h10,   32'h0,        32'h000000FF};
    vecs[5]  = '{1'b0, 3'b010, 32'h10,   32'h0,        32'h800000FF};
    vecs[6]  = '{1'b0, 3'b001, 32'h12,   32'h0,        32'hFFFF8000};
    vecs[7]  = '{1'b0, 3'b101, 32'h12,   32'h0,        32'h00008000};
    vecs[8]  = '{1'b0, 3'b000, 32'h13,   32'h0,        32'hFFFFFF80};
    vecs[9]  = '{1'b0, 3'b011, 32'h10,   32'h0,        32'h0};
    vecs[10] = '{1'b0, 3'b110, 32'h10,   32'h0,        32'h0};
    vecs[11] = '{1'b0, 3'b111, 32'h10,   32'h0,        32'h0};
    vecs[12] = '{1'b1, 3'b010, 32'h20,   32'h11223344, 32'h0};
    vecs[13] = '{1'b1, 3'b000, 32'h22,   32'hFFFFFFAA, 32'h0};
    vecs[14] = '{1'b1, 3'b001, 32'h20,   32'h1234BEEF, 32'h0};
    vecs[15] = '{1'b0, 3'b010, 32'h20,   32'h0,        32'h11AABEEF};
    vecs[16] = '{1'b0, 3'b000, 32'h23,   32'h0,        32'h00000011};
    vecs[17] = '{1'b0, 3'b010, 32'h21,   32'h0,        32'h11AABEEF};
    vecs[18] = '{1'b0, 3'b001, 32'h21,   32'h0,        32'hFFFFBEEF};
    vecs[19] = '{1'b0, 3'b010, 32'h1020, 32'h0,        32'h11AABEEF};

    // Reset state, counter held at zero while reset is asserted
    funct3 = 3'b010; addr = MB;
    #1;
    check("rst_gpio", {24'd0, gpio_out}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    repeat (3) @(negedge clk);
    #1 check("rst_cycle_lo", rd, 32'd0);
    addr = MB + 32'h10;
    #1 check("rst_fault_addr", rd, 32'd0);
    addr = MB + 32'h04;
    #1 check("rst_cycle_hi", rd, 32'd0);
    @(negedge clk);
    reset = 1'b0; addr = MB;
    @(negedge clk);
    #1 check("cycle_first", rd, 32'd1);

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].st) doStore(vecs[i].f3, vecs[i].a, vecs[i].d);
      else begin
        doLoad(vecs[i].f3, vecs[i].a, r);
        check($sformatf("vec%0d", i), r, vecs[i].exp);
      end
    end
    check("vec_no_fault", {31'd0, fault}, 32'd0);

    // Misaligned stores: no write, sticky fault, first address held, W1C clear
    doStore(3'b010, 32'h40, 32'hCAFEF00D);
    doStore(3'b010, 32'h42, 32'h12345678);
    check("mis_sw_fault", {31'd0, fault}, 32'd1);
    doLoad(3'b010, 32'h40, r);     check("mis_sw_nowrite", r, 32'hCAFEF00D);
    doLoad(3'b010, MB + 32'h10, r); check("fault_addr_first", r, 32'h42);
    doStore(3'b001, 32'h41, 32'h0000FFFF);
    doLoad(3'b010, MB + 32'h10, r); check("fault_addr_held", r, 32'h42);
    doLoad(3'b010, 32'h40, r);     check("mis_sh_nowrite", r, 32'hCAFEF00D);
    doLoad(3'b010, MB + 32'h0C, r); check("fault_status", r, 32'd1);
    doStore(3'b010, MB + 32'h0C, 32'd1);
    check("fault_clear", {31'd0, fault}, 32'd0);
    doLoad(3'b010, MB + 32'h10, r); check("fault_addr_kept", r, 32'h42);
    doStore(3'b011, 32'h44, 32'h0);
    check("illegal_f3_fault", {31'd0, fault}, 32'd1);
    doLoad(3'b010, MB + 32'h10, r); check("fault_addr_new", r, 32'h44);
    doStore(3'b010, MB + 32'h0C, 32'd1);

    // GPIO: only aligned SW writes; sub-word loads extend lanes
    doStore(3'b010, MB + 32'h08, 32'h000001A5);
    check("gpio_set", {24'd0, gpio_out}, 32'hA5);
    doLoad(3'b010, MB + 32'h08, r); check("gpio_lw", r, 32'h000000A5);
    doLoad(3'b000, MB + 32'h08, r); check("gpio_lb", r, 32'hFFFFFFA5);
    doStore(3'b000, MB + 32'h08, 32'h0);
    doStore(3'b001, MB + 32'h08, 32'h0);
    check("gpio_sb_ignored", {24'd0, gpio_out}, 32'hA5);
    check("gpio_sb_nofault", {31'd0, fault}, 32'd0);
    doStore(3'b010, MB + 32'h14, 32'hFFFFFFFF);
    doLoad(3'b010, MB + 32'h14, r); check("mmio_unmapped", r, 32'd0);

    // Read-during-write returns old data, new data on the following cycle
    doStore(3'b010, 32'h50, 32'h0BADCAFE);
    @(negedge clk);
    we = 1'b1; funct3 = 3'b010; addr = 32'h50; wd = 32'h600DF00D;
    #1 check("rdw_old", rd, 32'h0BADCAFE);
    @(posedge clk);
    #1 we = 1'b0;
    #1 check("rdw_new", rd, 32'h600DF00D);

    // Cycle counter advance and 64-bit wrap
    doLoad(3'b010, MB, r);
    repeat (10) @(negedge clk);
    #1 r2 = rd;
    check("cycle_delta", r2 - r, 32'd10);
    @(negedge clk);
    force dut.cycleCnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 check("cycle_max_lo", rd, 32'hFFFFFFFF);
    #1 release dut.cycleCnt;
    @(negedge clk);
    #1 check("cycle_wrap_lo", rd, 32'd0);
    addr = MB + 32'h04;
    #1 check("cycle_wrap_hi", rd, 32'd0);

    // Asynchronous reset mid-run drops the store in flight and keeps RAM
    doStore(3'b010, 32'h60, 32'h5EED1234);
    doStore(3'b010, 32'h46, 32'h0);
    check("pre_rst_fault", {31'd0, fault}, 32'd1);
    @(negedge clk);
    we = 1'b1; funct3 = 3'b010; addr = 32'h60; wd = 32'hDEADBEEF;
    #2 reset = 1'b1;
    #1;
    check("async_rst_gpio", {24'd0, gpio_out}, 32'd0);
    check("async_rst_fault", {31'd0, fault}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    we = 1'b0; reset = 1'b0;
    doLoad(3'b010, 32'h60, r); check("rst_store_dropped", r, 32'h5EED1234);
    doLoad(3'b010, 32'h40, r); check("rst_ram_kept", r, 32'hCAFEF00D);

    // Randomized RAM traffic against the byte-array model
    for (int w = 0; w < 16; w++) begin
      r2 = $urandom;
      doStore(3'b010, 32'h100 + 32'(4 * w), r2);
      modelStore(3'b010, 32'h100 + 32'(4 * w), r2);
    end
    for (int it = 0; it < 400; it++) begin
      logic [2:0]  f3;
      logic [31:0] a, d;
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 255)) << 12);
      d  = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        doStore(f3, a, d);
        modelStore(f3, a, d);
        check("rnd_fault", {31'd0, fault}, {31'd0, mFault});
      end else begin
        doLoad(f3, a, r);
        check($sformatf("rnd_load f3=%0d a=%h", f3, a), r, modelLoad(f3, a));
      end
      if (it % 50 == 49 && mFault) begin
        doLoad(3'b010, MB + 32'h10, r);
        check("rnd_fault_addr", r, mFaultAddr);
        doStore(3'b010, MB + 32'h0C, 32'd1);
        mFault = 1'b0;
        check("rnd_fault_clear", {31'd0, fault}, 32'd0);
      end
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
